// File: rtl/pls2tgl_hs.sv
// Multi-channel pulse-to-toggle source cell. Pulses are queued per channel and issued as
// toggles only once the destination has echoed the previous toggle back on ack_tgl_i.
module pls2tgl_hs #(
  parameter int CHANNELS    = 1,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HANDSHAKE   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       pulse_i,
  input  logic [CHANNELS-1:0]       ack_tgl_i,
  input  logic [CHANNELS-1:0]       ovf_clr_i,
  output logic [CHANNELS-1:0]       tgl_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS*CNT_W-1:0] pend_o,
  output logic [CHANNELS-1:0]       ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   tgl_q, tgl_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   ack_s, busy, issue, pulse, ovf_set;

    assign pulse = pulse_i[ch];
    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // ack_tgl_i arrives from another clock domain; only the last stage is used
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ack_sync_q <= '0;
      end else begin
        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_i[ch]};
      end
    end

    always_comb begin
      busy    = 1'b0;
      issue   = 1'b0;
      ovf_set = 1'b0;
      tgl_d   = tgl_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (HANDSHAKE != 0) begin
        busy  = tgl_q ^ ack_s;
        issue = !busy && ((cnt_q != '0) || pulse);
        tgl_d = tgl_q ^ issue;
        // An issue consumes one event; a simultaneous pulse replaces it in the queue
        if (issue) begin
          if (!pulse) cnt_d = cnt_q - CNT_ONE;
        end else if (pulse) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          else                  ovf_set = 1'b1;
        end
        if (ovf_set)             ovf_d = 1'b1;
        else if (ovf_clr_i[ch])  ovf_d = 1'b0;
      end else begin
        tgl_d = tgl_q ^ pulse;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tgl_q <= 1'b0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        tgl_q <= tgl_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign tgl_o[ch]                 = tgl_q;
    assign busy_o[ch]                = busy;
    assign pend_o[ch*CNT_W +: CNT_W] = cnt_q;
    assign ovf_o[ch]                 = ovf_q;
  end

endmodule

// File: tb/tb_pls2tgl_hs.sv
// Directed bench for pls2tgl_hs: handshake, queueing, overflow, legacy mode and async reset.
module tb_pls2tgl_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // dut_a: 4 channels, CNT_W=4, handshake
  logic [3:0]  pulse_a, ack_a, clr_a, tgl_a, busy_a, ovf_a;
  logic [15:0] pend_a;
  // dut_b: 1 channel, CNT_W=2, handshake
  logic [0:0]  pulse_b, ack_b, clr_b, tgl_b, busy_b, ovf_b;
  logic [1:0]  pend_b;
  // dut_c: 1 channel, legacy mode
  logic [0:0]  pulse_c, ack_c, clr_c, tgl_c, busy_c, ovf_c;
  logic [3:0]  pend_c;

  int tests_run = 0;
  int tests_failed = 0;

  pls2tgl_hs #(.CHANNELS(4), .CNT_W(4), .SYNC_STAGES(2), .HANDSHAKE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse_a), .ack_tgl_i(ack_a), .ovf_clr_i(clr_a),
    .tgl_o(tgl_a), .busy_o(busy_a), .pend_o(pend_a), .ovf_o(ovf_a));
  pls2tgl_hs #(.CHANNELS(1), .CNT_W(2), .SYNC_STAGES(2), .HANDSHAKE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse_b), .ack_tgl_i(ack_b), .ovf_clr_i(clr_b),
    .tgl_o(tgl_b), .busy_o(busy_b), .pend_o(pend_b), .ovf_o(ovf_b));
  pls2tgl_hs #(.CHANNELS(1), .CNT_W(4), .SYNC_STAGES(2), .HANDSHAKE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse_c), .ack_tgl_i(ack_c), .ovf_clr_i(clr_c),
    .tgl_o(tgl_c), .busy_o(busy_c), .pend_o(pend_c), .ovf_o(ovf_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pulse_a = '0; ack_a = '0; clr_a = '0;
    pulse_b = '0; ack_b = '0; clr_b = '0;
    pulse_c = '0; ack_c = '0; clr_c = '0;
    repeat (2) tick;
    if (tgl_a !== 4'h0) begin $display("FAIL rst_tgl_a: got %h expected 0", tgl_a); tests_failed++; end
    tests_run++;
    if (busy_a !== 4'h0) begin $display("FAIL rst_busy_a: got %h expected 0", busy_a); tests_failed++; end
    tests_run++;
    if (pend_a !== 16'h0) begin $display("FAIL rst_pend_a: got %h expected 0", pend_a); tests_failed++; end
    tests_run++;
    if (ovf_a !== 4'h0) begin $display("FAIL rst_ovf_a: got %h expected 0", ovf_a); tests_failed++; end
    tests_run++;
    if ({tgl_b, pend_b, ovf_b, tgl_c} !== 5'b0) begin
      $display("FAIL rst_bc: got %b expected 00000", {tgl_b, pend_b, ovf_b, tgl_c}); tests_failed++;
    end
    tests_run++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    pulse_a[0] = 1'b1;
    tick;
    pulse_a[0] = 1'b0;
    if (tgl_a[0] !== 1'b1) begin $display("FAIL t1_tgl: got %b expected 1", tgl_a[0]); tests_failed++; end
    tests_run++;
    if (busy_a[0] !== 1'b1) begin $display("FAIL t1_busy: got %b expected 1", busy_a[0]); tests_failed++; end
    tests_run++;
    ack_a[0] = 1'b1;
    tick;
    if (busy_a[0] !== 1'b1) begin $display("FAIL t1_busy_early: got %b expected 1", busy_a[0]); tests_failed++; end
    tests_run++;
    tick;
    if (busy_a[0] !== 1'b0) begin $display("FAIL t1_busy_clr: got %b expected 0", busy_a[0]); tests_failed++; end
    tests_run++;
    if (pend_a[3:0] !== 4'd0) begin $display("FAIL t1_pend: got %0d expected 0", pend_a[3:0]); tests_failed++; end
    tests_run++;
  endtask

  task automatic test_back_to_back;
    pulse_a[0] = 1'b1;
    repeat (3) tick;
    pulse_a[0] = 1'b0;
    if (tgl_a[0] !== 1'b0) begin $display("FAIL t2_tgl1: got %b expected 0", tgl_a[0]); tests_failed++; end
    tests_run++;
    if (pend_a[3:0] !== 4'd2) begin $display("FAIL t2_pend2: got %0d expected 2", pend_a[3:0]); tests_failed++; end
    tests_run++;
    repeat (5) tick;
    if ({tgl_a[0], pend_a[3:0]} !== 5'b0_0010) begin
      $display("FAIL t2_hold: got %b expected 00010", {tgl_a[0], pend_a[3:0]}); tests_failed++;
    end
    tests_run++;
    ack_a[0] = 1'b0;
    repeat (3) tick;
    if (tgl_a[0] !== 1'b1) begin $display("FAIL t2_tgl2: got %b expected 1", tgl_a[0]); tests_failed++; end
    tests_run++;
    if (pend_a[3:0] !== 4'd1) begin $display("FAIL t2_pend1: got %0d expected 1", pend_a[3:0]); tests_failed++; end
    tests_run++;
    repeat (5) tick;
    ack_a[0] = 1'b1;
    repeat (3) tick;
    if (tgl_a[0] !== 1'b0) begin $display("FAIL t2_tgl3: got %b expected 0", tgl_a[0]); tests_failed++; end
    tests_run++;
    if (pend_a[3:0] !== 4'd0) begin $display("FAIL t2_pend0: got %0d expected 0", pend_a[3:0]); tests_failed++; end
    tests_run++;
    ack_a[0] = 1'b0;
    repeat (2) tick;
    if (busy_a[0] !== 1'b0) begin $display("FAIL t2_idle: got %b expected 0", busy_a[0]); tests_failed++; end
    tests_run++;
  endtask

  task automatic test_pulse_at_release;
    pulse_a[0] = 1'b1;
    repeat (2) tick;
    pulse_a[0] = 1'b0;
    if ({tgl_a[0], pend_a[3:0]} !== 5'b1_0001) begin
      $display("FAIL t4_setup: got %b expected 10001", {tgl_a[0], pend_a[3:0]}); tests_failed++;
    end
    tests_run++;
    ack_a[0] = 1'b1;
    repeat (2) tick;
    if (busy_a[0] !== 1'b0) begin $display("FAIL t4_busy: got %b expected 0", busy_a[0]); tests_failed++; end
    tests_run++;
    pulse_a[0] = 1'b1;
    tick;
    pulse_a[0] = 1'b0;
    if (tgl_a[0] !== 1'b0) begin $display("FAIL t4_tgl: got %b expected 0", tgl_a[0]); tests_failed++; end
    tests_run++;
    if (pend_a[3:0] !== 4'd1) begin $display("FAIL t4_pend: got %0d expected 1", pend_a[3:0]); tests_failed++; end
    tests_run++;
    ack_a[0] = 1'b0;
    repeat (3) tick;
    ack_a[0] = 1'b1;
    repeat (2) tick;
    if ({tgl_a[0], busy_a[0], pend_a[3:0]} !== 6'b10_0000) begin
      $display("FAIL t4_drain: got %b expected 100000", {tgl_a[0], busy_a[0], pend_a[3:0]}); tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_legacy;
    logic [3:0] exp_seq;
    exp_seq = 4'b0101;
    pulse_c = 1'b1;
    ack_c = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick;
      if (tgl_c[0] !== ~exp_seq[i]) begin
        $display("FAIL t6_legacy_tgl%0d: got %b expected %b", 3 - i, tgl_c[0], ~exp_seq[i]); tests_failed++;
      end
      tests_run++;
    end
    pulse_c = 1'b0;
    tick;
    if ({busy_c, pend_c, ovf_c} !== 6'b0) begin
      $display("FAIL t6_legacy_flags: got %b expected 000000", {busy_c, pend_c, ovf_c}); tests_failed++;
    end
    tests_run++;
    ack_c = 1'b0;
  endtask

  task automatic test_overflow;
    pulse_b = 1'b1;
    repeat (4) tick;
    if (pend_b !== 2'd3) begin $display("FAIL t3_pend: got %0d expected 3", pend_b); tests_failed++; end
    tests_run++;
    if (ovf_b !== 1'b0) begin $display("FAIL t3_ovf_early: got %b expected 0", ovf_b); tests_failed++; end
    tests_run++;
    tick;
    if (ovf_b !== 1'b1) begin $display("FAIL t3_ovf: got %b expected 1", ovf_b); tests_failed++; end
    tests_run++;
    if ({tgl_b, pend_b} !== 3'b111) begin $display("FAIL t3_tgl_pend: got %b expected 111", {tgl_b, pend_b}); tests_failed++; end
    tests_run++;
    clr_b = 1'b1;
    tick;
    if (ovf_b !== 1'b1) begin $display("FAIL t3_set_prio: got %b expected 1", ovf_b); tests_failed++; end
    tests_run++;
    pulse_b = 1'b0;
    tick;
    clr_b = 1'b0;
    if (ovf_b !== 1'b0) begin $display("FAIL t3_clr: got %b expected 0", ovf_b); tests_failed++; end
    tests_run++;
  endtask

  task automatic test_async_reset;
    pulse_a[0] = 1'b1;
    repeat (3) tick;
    pulse_a[0] = 1'b0;
    if ({tgl_a[0], pend_a[3:0]} !== 5'b0_0010) begin
      $display("FAIL t6_rst_setup: got %b expected 00010", {tgl_a[0], pend_a[3:0]}); tests_failed++;
    end
    tests_run++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({tgl_a, busy_a, ovf_a} !== 12'h0) begin
      $display("FAIL t6_rst_flags: got %h expected 000", {tgl_a, busy_a, ovf_a}); tests_failed++;
    end
    tests_run++;
    if (pend_a !== 16'h0) begin $display("FAIL t6_rst_pend: got %h expected 0", pend_a); tests_failed++; end
    tests_run++;
    if ({tgl_b, pend_b} !== 3'b000) begin $display("FAIL t6_rst_b: got %b expected 000", {tgl_b, pend_b}); tests_failed++; end
    tests_run++;
    ack_a = '0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_multi_channel;
    int sent[4];
    int recv[4];
    int dly[4];
    logic [3:0] last;
    for (int c = 0; c < 4; c++) begin sent[c] = 0; recv[c] = 0; dly[c] = 0; end
    last = tgl_a;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (tgl_a[c] != last[c]) begin recv[c]++; last[c] = tgl_a[c]; end
        if (tgl_a[c] != ack_a[c]) begin
          if (dly[c] == 0) ack_a[c] = tgl_a[c];
          else dly[c]--;
        end else begin
          dly[c] = int'($urandom_range(0, 5 + c));
        end
        pulse_a[c] = 1'b0;
        if (cyc < 400 && (sent[c] - recv[c]) < 10 && $urandom_range(0, 2) == 0) begin
          pulse_a[c] = 1'b1;
          sent[c]++;
        end
      end
      tick;
    end
    for (int c = 0; c < 4; c++) begin
      if (recv[c] !== sent[c]) begin
        $display("FAIL t5_count_ch%0d: got %0d toggles expected %0d", c, recv[c], sent[c]); tests_failed++;
      end
      tests_run++;
    end
    if (pend_a !== 16'h0) begin $display("FAIL t5_pend: got %h expected 0", pend_a); tests_failed++; end
    tests_run++;
    if ({busy_a, ovf_a} !== 8'h0) begin $display("FAIL t5_flags: got %h expected 00", {busy_a, ovf_a}); tests_failed++; end
    tests_run++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_pulse_at_release;
    test_legacy;
    test_overflow;
    test_async_reset;
    test_multi_channel;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
